// File: rtl/gcd_arbiter_pkg.sv
// Shared types and default sizing for the GCD arbiter and its round-robin picker.
package gcd_arbiter_pkg;

  localparam int unsigned DEF_W = 16;
  localparam int unsigned DEF_N = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above i_ptr, wrapping modulo N.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int unsigned   w_j;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = 32'(i_ptr) + k;
      if (w_j >= N) begin
        w_j = w_j - N;
      end
      w_idx = IW'(w_j);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_idx          = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD unit among N requesters: round-robin grant, issue, wait for result,
// hand the result back to the granted requester.
module gcd_arbiter
  import gcd_arbiter_pkg::*;
#(
  parameter int unsigned W = DEF_W,
  parameter int unsigned N = DEF_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic [N-1:0]     rsp_valid,
  output logic [W-1:0]     rsp_data,
  input  logic [N-1:0]     rsp_taken,
  output logic             gcd_data_rdy,
  output logic [W-1:0]     gcd_a,
  output logic [W-1:0]     gcd_b,
  input  logic             gcd_result_rdy,
  input  logic [W-1:0]     gcd_result_data,
  output logic             gcd_result_taken,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_grant;
  logic [W-1:0]     r_gcd_a;
  logic [W-1:0]     r_gcd_b;
  logic [CNT_W-1:0] r_op_count;

  logic [N-1:0]     w_pick_grant;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic [N-1:0]     w_grant_oh;
  logic [IW-1:0]    w_ptr_inc;
  logic             w_taken;
  logic             w_capture;
  logic             w_complete;

  rr_pick #(.N(N)) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_pick_grant[i]) begin
        w_sel_a = req_a[i*W +: W];
        w_sel_b = req_b[i*W +: W];
      end
    end
  end

  assign w_grant_oh = N'(1) << r_grant;
  assign w_taken    = |(rsp_taken & w_grant_oh);
  assign w_ptr_inc  = (r_grant == IW'(N - 1)) ? '0 : r_grant + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_gcd_a    <= '0;
      r_gcd_b    <= '0;
      r_op_count <= '0;
    end else begin
      if (w_capture) begin
        r_grant <= w_pick_idx;
        r_gcd_a <= w_sel_a;
        r_gcd_b <= w_sel_b;
      end
      if (w_complete) begin
        r_op_count <= r_op_count + CNT_W'(1);
        r_ptr      <= w_ptr_inc;
      end
    end
  end

  // Handshake outputs are held at zero while reset is asserted.
  always_comb begin
    w_state_nxt      = r_state;
    w_capture        = 1'b0;
    w_complete       = 1'b0;
    req_ready        = '0;
    rsp_valid        = '0;
    rsp_data         = '0;
    gcd_data_rdy     = 1'b0;
    gcd_result_taken = 1'b0;
    busy             = 1'b0;
    if (!reset) begin
      unique case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            req_ready   = w_pick_grant;
            w_capture   = 1'b1;
            w_state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          busy         = 1'b1;
          gcd_data_rdy = 1'b1;
          w_state_nxt  = WAIT;
        end
        WAIT: begin
          busy = 1'b1;
          if (gcd_result_rdy) begin
            w_state_nxt = RESP;
          end
        end
        RESP: begin
          busy      = 1'b1;
          rsp_valid = w_grant_oh;
          rsp_data  = gcd_result_data;
          if (w_taken) begin
            gcd_result_taken = 1'b1;
            w_complete       = 1'b1;
            w_state_nxt      = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign gcd_a    = r_gcd_a;
  assign gcd_b    = r_gcd_b;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural multi-cycle GCD unit attached.
module tb_gcd_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_taken;
  logic        gcd_data_rdy;
  logic [15:0] gcd_a;
  logic [15:0] gcd_b;
  logic        gcd_result_rdy;
  logic [15:0] gcd_result_data;
  logic        gcd_result_taken;
  logic        busy;
  logic [15:0] op_count;

  int n_vec = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_taken = 0;
  int grants[$];
  int results[$];

  gcd_arbiter #(.W(16), .N(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_taken        (rsp_taken),
    .gcd_data_rdy     (gcd_data_rdy),
    .gcd_a            (gcd_a),
    .gcd_b            (gcd_b),
    .gcd_result_rdy   (gcd_result_rdy),
    .gcd_result_data  (gcd_result_data),
    .gcd_result_taken (gcd_result_taken),
    .busy             (busy),
    .op_count         (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] gcd_f(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // GCD unit model: result appears a few cycles after the start pulse, held until taken.
  logic        m_busy;
  logic [2:0]  m_cnt;
  logic [15:0] m_res;
  always @(posedge clk) begin
    if (reset) begin
      m_busy          <= 1'b0;
      m_cnt           <= 3'd0;
      gcd_result_rdy  <= 1'b0;
      gcd_result_data <= 16'd0;
    end else begin
      if (gcd_data_rdy) begin
        m_busy <= 1'b1;
        m_cnt  <= 3'd3;
        m_res  <= gcd_f(gcd_a, gcd_b);
      end else if (m_busy) begin
        if (m_cnt == 3'd0) begin
          m_busy          <= 1'b0;
          gcd_result_rdy  <= 1'b1;
          gcd_result_data <= m_res;
        end else begin
          m_cnt <= m_cnt - 3'd1;
        end
      end
      if (gcd_result_rdy && gcd_result_taken) begin
        gcd_result_rdy  <= 1'b0;
        gcd_result_data <= 16'd0;
      end
    end
  end

  always @(posedge clk) begin
    if (gcd_data_rdy)     n_start <= n_start + 1;
    if (gcd_result_taken) n_taken <= n_taken + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic wait_rsp(input int budget);
    for (int c = 0; c < budget && rsp_valid == 4'b0000; c++) begin
      cyc();
      #1;
    end
  endtask

  // Requesters drop their request the cycle after seeing req_ready; grants and
  // accepted results are logged in order.
  task automatic run_ops(input int n_ops, input int budget);
    logic [3:0] clr;
    int done;
    clr  = '0;
    done = 0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (req_ready != 4'b0000) begin
        clr = req_ready;
        grants.push_back(oh_idx(req_ready));
      end
      if ((rsp_valid & rsp_taken) != 4'b0000) begin
        results.push_back(int'(rsp_data));
        done++;
      end
      cyc();
      req_valid = req_valid & ~clr;
      clr = '0;
      if (done >= n_ops) break;
    end
  endtask

  task automatic check_log(input string tag, input int eg[], input int er[]);
    chk({tag, "_ngrant"}, grants.size(), eg.size());
    chk({tag, "_nresult"}, results.size(), er.size());
    for (int i = 0; i < eg.size(); i++) begin
      if (i < grants.size()) chk({tag, "_grant"}, grants[i], eg[i]);
    end
    for (int i = 0; i < er.size(); i++) begin
      if (i < results.size()) chk({tag, "_result"}, results[i], er[i]);
    end
    grants.delete();
    results.delete();
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_gcd_data_rdy"}, gcd_data_rdy, 0);
    chk({tag, "_gcd_a"}, gcd_a, 0);
    chk({tag, "_gcd_b"}, gcd_b, 0);
    chk({tag, "_gcd_result_taken"}, gcd_result_taken, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_op_count"}, op_count, 0);
  endtask

  initial begin
    int s0;
    int t0;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_taken = '0;
    repeat (3) @(posedge clk);
    #2;
    check_idle_zero("reset");
    reset = 1'b0;
    cyc();

    // Single request from requester 0: 48,18 -> 6
    set_req(0, 16'd48, 16'd18);
    req_valid = 4'b0001;
    rsp_taken = 4'b0001;
    s0 = n_start;
    #1;
    chk("t1_req_ready", req_ready, 4'b0001);
    chk("t1_busy_idle", busy, 0);
    cyc();
    req_valid = 4'b0000;
    #1;
    chk("t1_start", gcd_data_rdy, 1);
    chk("t1_gcd_a", gcd_a, 48);
    chk("t1_gcd_b", gcd_b, 18);
    chk("t1_busy", busy, 1);
    chk("t1_no_regrant", req_ready, 0);
    cyc();
    #1;
    chk("t1_start_once", gcd_data_rdy, 0);
    wait_rsp(40);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_data", rsp_data, 6);
    chk("t1_result_taken", gcd_result_taken, 1);
    chk("t1_start_pulses", n_start - s0, 1);
    cyc();
    #1;
    chk("t1_op_count", op_count, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_rsp_cleared", rsp_valid, 0);
    chk("t1_rsp_data_zero", rsp_data, 0);

    // All four at once from ptr=0
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    grants.delete();
    results.delete();
    set_req(0, 16'd12, 16'd8);
    set_req(1, 16'd35, 16'd14);
    set_req(2, 16'd0, 16'd7);
    set_req(3, 16'd9, 16'd0);
    req_valid = 4'b1111;
    rsp_taken = 4'b1111;
    run_ops(4, 300);
    check_log("t2", '{0, 1, 2, 3}, '{4, 7, 7, 9});
    chk("t2_op_count", op_count, 4);

    // ptr wrapped back to 0: requester 0 beats requester 3
    set_req(0, 16'd100, 16'd75);
    set_req(3, 16'd17, 16'd5);
    req_valid = 4'b1001;
    run_ops(2, 200);
    check_log("t2_wrap", '{0, 3}, '{25, 1});

    // After req2 completes, ptr=3: req3 before req1
    set_req(2, 16'd27, 16'd36);
    req_valid = 4'b0100;
    run_ops(1, 100);
    set_req(1, 16'd8, 16'd12);
    set_req(3, 16'd25, 16'd15);
    req_valid = 4'b1010;
    run_ops(2, 200);
    check_log("t3", '{2, 3, 1}, '{9, 5, 4});
    chk("t3_op_count", op_count, 9);

    // Response held 10 cycles; other requesters' rsp_taken bits must not complete it
    set_req(0, 16'd20, 16'd8);
    set_req(2, 16'd14, 16'd21);
    req_valid = 4'b0001;
    rsp_taken = 4'b0000;
    #1;
    chk("t4_req_ready", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0000;
    wait_rsp(40);
    req_valid = 4'b0100;
    rsp_taken = 4'b1110;
    t0 = n_taken;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("t4_hold_valid", rsp_valid, 4'b0001);
      chk("t4_hold_data", rsp_data, 4);
      chk("t4_hold_taken", gcd_result_taken, 0);
      chk("t4_hold_nogrant", req_ready, 0);
      cyc();
      #1;
    end
    rsp_taken = 4'b0001;
    #1;
    chk("t4_release_taken", gcd_result_taken, 1);
    chk("t4_release_data", rsp_data, 4);
    cyc();
    rsp_taken = 4'b1111;
    #1;
    chk("t4_taken_pulses", n_taken - t0, 1);
    chk("t4_taken_low", gcd_result_taken, 0);
    chk("t4_next_grant", req_ready, 4'b0100);
    chk("t4_op_count", op_count, 10);
    grants.delete();
    results.delete();
    run_ops(1, 100);
    check_log("t4_req2", '{2}, '{7});

    // Reset during WAIT abandons the operation
    set_req(1, 16'd1071, 16'd462);
    req_valid = 4'b0010;
    #1;
    chk("t5_req_ready", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0000;
    cyc();
    #1;
    chk("t5_wait_busy", busy, 1);
    chk("t5_wait_no_rsp", rsp_valid, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check_idle_zero("t5_after_reset");
    grants.delete();
    results.delete();
    set_req(1, 16'd21, 16'd6);
    req_valid = 4'b0010;
    rsp_taken = 4'b1111;
    run_ops(1, 100);
    check_log("t5_new", '{1}, '{3});
    chk("t5_op_count", op_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
